// File: rtl/jk_cmd_arbiter.sv
// Shared bank of NFF JK state bits; NREQ requesters post commands arbitrated round-robin.
// Latency: gnt registered one cycle after req is sampled in IDLE; q updates at the edge ending APPLY.
// Backpressure: requesters hold req/cmd/idx until gnt; one command per 2 cycles. Macro JKARB_FIXED_PRIO_EN selects fixed priority.
module jk_cmd_arbiter #(
  parameter int NREQ = 4,
  parameter int NFF  = 6,
  parameter int IDXW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    cmd,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 err,
  output logic [NFF-1:0]       q,
  output logic [NFF-1:0]       qbar
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, APPLY} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   win;
  logic            win_vld;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      cmd_w;
  logic [IDXW-1:0] idx_w;
  logic [1:0]      cmd_l;
  logic [IDXW-1:0] idx_l;
  logic            idx_ok;
  logic [NFF-1:0]  q_nxt;

`ifdef JKARB_FIXED_PRIO_EN
  // Fixed priority: lowest-index active request wins (scan high to low, last hit kept).
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win     = PW'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;

  // Round-robin search starting at ptr; first active request in circular order wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (!win_vld && req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on each grant; untouched otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (state == IDLE && win_vld) begin
      ptr <= PW'((int'(win) + 1) % NREQ);
    end
  end
`endif

  // Decode winner into a one-hot grant and pick out its command and index fields.
  always_comb begin
    win_oh = '0;
    cmd_w  = '0;
    idx_w  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_vld && win == PW'(i)) begin
        win_oh[i] = 1'b1;
        cmd_w     = cmd[2*i +: 2];
        idx_w     = idx[IDXW*i +: IDXW];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: arbitrate only in IDLE; APPLY always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = APPLY;
      APPLY:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // JK update of the addressed bit; an out-of-range index matches no bit and leaves q alone.
  always_comb begin
    q_nxt = q;
    for (int i = 0; i < NFF; i++) begin
      if (idx_l == IDXW'(i)) begin
        case (cmd_l)
          2'b01:   q_nxt[i] = 1'b0;
          2'b10:   q_nxt[i] = 1'b1;
          2'b11:   q_nxt[i] = ~q[i];
          default: q_nxt[i] = q[i];
        endcase
      end
    end
  end

  // Grant pulse and command capture at the arbitration edge; bank update at the APPLY edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt   <= '0;
      cmd_l <= '0;
      idx_l <= '0;
      q     <= '0;
    end else begin
      gnt <= '0;
      if (state == IDLE && win_vld) begin
        gnt   <= win_oh;
        cmd_l <= cmd_w;
        idx_l <= idx_w;
      end
      if (state == APPLY) begin
        q <= q_nxt;
      end
    end
  end

  assign idx_ok = (int'(idx_l) < NFF);
  assign busy   = (state == APPLY);
  assign err    = busy && !idx_ok;
  assign qbar   = ~q;

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
module tb_jk_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int NFF  = 6;
  localparam int IDXW = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            req;
  logic [3:0][1:0]       cmd_a;
  logic [3:0][2:0]       idx_a;
  logic [3:0]            gnt;
  logic                  busy, err;
  logic [5:0]            q, qbar;

  jk_cmd_arbiter #(.NREQ(NREQ), .NFF(NFF), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd(cmd_a), .idx(idx_a),
    .gnt(gnt), .busy(busy), .err(err), .q(q), .qbar(qbar)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    logic       e;
    logic [5:0] qpre;
    logic [5:0] qpost;
  } exp_t;

  exp_t sbq[$];

  // reference model state
  int         ptr_m  = 0;
  bit         wait_m = 0;   // one idle edge after each grant (command being applied)
  logic [5:0] q_m    = '0;
  int         won    = -1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  function automatic int pick();
    int start;
`ifdef JKARB_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr_m;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int r;
      r = (start + k) % NREQ;
      if (req[r[1:0]]) return r;
    end
    return -1;
  endfunction

  // Evaluate the edge that just happened using the inputs it sampled.
  task automatic step();
    int w;
    logic [1:0] c;
    logic [2:0] ix;
    exp_t e;
    won = -1;
    if (wait_m) begin
      wait_m = 0;
    end else begin
      w = pick();
      if (w >= 0) begin
        c       = cmd_a[w[1:0]];
        ix      = idx_a[w[1:0]];
        e.g     = 4'b0001 << w;
        e.e     = (int'(ix) >= NFF);
        e.qpre  = q_m;
        if (int'(ix) < NFF) begin
          case (c)
            2'b01:   q_m[ix] = 1'b0;
            2'b10:   q_m[ix] = 1'b1;
            2'b11:   q_m[ix] = ~q_m[ix];
            default: ;
          endcase
        end
        e.qpost = q_m;
        sbq.push_back(e);
        ptr_m  = (w + 1) % NREQ;
        wait_m = 1;
        won    = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
  endtask

  task automatic wait_grant(input int r, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (won != r && n < 20);
    if (won != r) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: requester %0d not granted within %0d cycles", r, n);
    end
  endtask

  // Monitor: pops an expectation whenever a grant pulse appears.
  bit         post_pending = 0;
  logic [5:0] post_q;
  always @(negedge clk) begin
    exp_t e;
    logic [5:0] nq;
    if (!reset) begin
      post_pending = 0;
    end else begin
      nq = ~q;
      chk("qbar", qbar, nq);
      if (post_pending) begin
        chk("q_after_apply", q, post_q);
        post_pending = 0;
      end
      if (gnt != 4'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_gnt: got %b with nothing expected", gnt);
        end else begin
          e = sbq.pop_front();
          chk("gnt", gnt, e.g);
          chk("err", err, e.e);
          chk("busy_apply", busy, 1);
          chk("q_during_apply", q, e.qpre);
          post_pending = 1;
          post_q       = e.qpost;
        end
      end else begin
        chk("busy_idle", busy, 0);
        chk("err_idle", err, 0);
      end
    end
  end

  initial begin
    int n;
    int exp_next;
    logic [1:0] sweep [5];
    sweep[0] = 2'b10; sweep[1] = 2'b11; sweep[2] = 2'b11; sweep[3] = 2'b01; sweep[4] = 2'b00;

    reset = 1'b0;
    req   = '0;
    cmd_a = '0;
    idx_a = '0;
    #3;
    chk("rst_q", q, 6'h00);
    chk("rst_qbar", qbar, 6'h3f);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // single requester
    req = 4'b0010; cmd_a[1] = 2'b10; idx_a[1] = 3'd3;
    wait_grant(1, n);
    chk("single_latency", n, 1);
    req = '0;
    tick(); tick();
    chk("single_q", q, 6'b001000);

    // JK sweep on bit 0 from requester 0, command changed at each grant
    req[0] = 1'b1; idx_a[0] = 3'd0;
    for (int s = 0; s < 5; s++) begin
      cmd_a[0] = sweep[s];
      wait_grant(0, n);
      if (s > 0) chk("sweep_spacing", n, 2);
    end
    req = '0;
    tick(); tick();

    // contention: everyone toggles bit 2
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 2'b11;
      idx_a[i] = 3'd2;
    end
    repeat (12) tick();
    req = '0;
    tick(); tick();

    // out-of-range index from requester 2, then check who goes next
    req = 4'b0100; cmd_a[2] = 2'b10; idx_a[2] = 3'd7;
    wait_grant(2, n);
    req = 4'b1011;
    n = 0;
    do begin tick(); n++; end while (won < 0 && n < 10);
`ifdef JKARB_FIXED_PRIO_EN
    exp_next = 0;
`else
    exp_next = 3;
`endif
    chk("next_after_oor", won, exp_next);
    req = '0;
    tick(); tick();

    // reset asserted while applying a command
    req = 4'b0001; cmd_a[0] = 2'b10; idx_a[0] = 3'd5;
    wait_grant(0, n);
    chk("busy_before_rst", busy, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", q, 6'h00);
    chk("arst_qbar", qbar, 6'h3f);
    chk("arst_busy", busy, 0);
    chk("arst_gnt", gnt, 0);
    sbq.delete();
    wait_m = 0;
    ptr_m  = 0;
    q_m    = '0;
    req    = 4'b1111;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("first_after_rst", won, 0);
    req = '0;
    tick(); tick();

    // randomized traffic with the hold-until-grant rule and occasional abandonment
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (won == i || !req[i[1:0]]) begin
          if ($urandom_range(0, 1) == 1) begin
            req[i[1:0]]   = 1'b1;
            cmd_a[i[1:0]] = 2'($urandom_range(0, 3));
            idx_a[i[1:0]] = 3'($urandom_range(0, 7));
          end else begin
            req[i[1:0]] = 1'b0;
          end
        end else if ($urandom_range(0, 15) == 0) begin
          req[i[1:0]] = 1'b0;
        end
      end
      tick();
    end

    req = '0;
    repeat (4) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    chk("final_q", q, q_m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
